// File: rtl/bus_grant_scheduler.sv
// Round-robin owner scheduler for the shared system bus: one owner at a time,
// released on done, withdrawal or hold timeout, followed by one turnaround cycle.
module bus_grant_scheduler #(
    parameter int unsigned NREQ     = 16,
    parameter int unsigned IDX_W    = 4,
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NREQ-1:0]  req,
    input  logic             done,
    output logic             grant_valid,
    output logic [IDX_W-1:0] grant_idx,
    output logic [NREQ-1:0]  grant_onehot,
    output logic             timeout
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] ptr;
    logic [CNT_W-1:0] hold_cnt;

    logic             win_found;
    logic [IDX_W-1:0] win_idx;
    logic             rel_done;
    logic             rel_drop;
    logic             rel_limit;
    logic             release_now;

    // First requester at or above ptr, wrapping modulo NREQ.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (!win_found && req[IDX_W'(ptr + IDX_W'(k))]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(ptr + IDX_W'(k));
            end
        end
    end

    assign rel_done    = done;
    assign rel_drop    = ~req[grant_idx];
    assign rel_limit   = (hold_cnt == HOLD_LAST);
    assign release_now = rel_done | rel_drop | rel_limit;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            ptr          <= '0;
            hold_cnt     <= '0;
            grant_valid  <= 1'b0;
            grant_idx    <= '0;
            grant_onehot <= '0;
            timeout      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    timeout <= 1'b0;
                    if (win_found) begin
                        state        <= GRANT;
                        hold_cnt     <= '0;
                        grant_valid  <= 1'b1;
                        grant_idx    <= win_idx;
                        grant_onehot <= NREQ'(1) << win_idx;
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        state        <= TURN;
                        ptr          <= grant_idx + IDX_W'(1);
                        hold_cnt     <= '0;
                        grant_valid  <= 1'b0;
                        grant_idx    <= '0;
                        grant_onehot <= '0;
                        // Done or withdrawal outranks the hold limit.
                        timeout      <= rel_limit & ~rel_done & ~rel_drop;
                    end else begin
                        hold_cnt <= hold_cnt + CNT_W'(1);
                    end
                end
                TURN: begin
                    state   <= IDLE;
                    timeout <= 1'b0;
                end
                default: begin
                    state        <= IDLE;
                    grant_valid  <= 1'b0;
                    grant_idx    <= '0;
                    grant_onehot <= '0;
                    timeout      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_grant_scheduler.sv
// Self-checking bench for bus_grant_scheduler: directed scenarios plus a
// randomized run compared against a cycle-level behavioural model.
module tb_bus_grant_scheduler;

    localparam int unsigned NREQ     = 16;
    localparam int unsigned IDX_W    = 4;
    localparam int unsigned MAX_HOLD = 8;

    logic             clk;
    logic             reset;
    logic [NREQ-1:0]  req;
    logic             done;
    logic             grant_valid;
    logic [IDX_W-1:0] grant_idx;
    logic [NREQ-1:0]  grant_onehot;
    logic             timeout;

    int total;
    int bad;

    // Behavioural model: current owner (-1 none), cycles held, gap cycles left.
    int m_owner;
    int m_held;
    int m_gap;
    int m_ptr;
    bit m_to;

    logic [21:0] dut_v;
    assign dut_v = {grant_valid, grant_idx, grant_onehot, timeout};

    bus_grant_scheduler #(
        .NREQ(NREQ), .IDX_W(IDX_W), .MAX_HOLD(MAX_HOLD)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req(req),
        .done(done),
        .grant_valid(grant_valid),
        .grant_idx(grant_idx),
        .grant_onehot(grant_onehot),
        .timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [21:0] exp_v();
        logic [3:0]  i;
        logic [15:0] oh;
        i  = (m_owner >= 0) ? 4'(m_owner) : 4'd0;
        oh = (m_owner >= 0) ? (16'd1 << m_owner) : 16'd0;
        return {(m_owner >= 0), i, oh, m_to};
    endfunction

    task automatic model_step();
        if (reset) begin
            m_owner = -1; m_held = 0; m_gap = 0; m_ptr = 0; m_to = 0;
        end else if (m_owner >= 0) begin
            if (done || !req[m_owner] || m_held == MAX_HOLD) begin
                m_to    = !done && req[m_owner];
                m_ptr   = (m_owner + 1) % NREQ;
                m_owner = -1;
                m_gap   = 1;
            end else begin
                m_held++;
                m_to = 0;
            end
        end else if (m_gap > 0) begin
            m_gap = 0;
            m_to  = 0;
        end else begin
            m_to = 0;
            for (int k = 0; k < NREQ; k++) begin
                if (req[(m_ptr + k) % NREQ]) begin
                    m_owner = (m_ptr + k) % NREQ;
                    m_held  = 1;
                    break;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; req = 16'hFFFF; done = 1'b0;
        for (int c = 0; c < 2; c++) begin
            tick();
            total++;
            if (dut_v !== 22'd0) begin
                bad++;
                $display("FAIL reset_outputs: got %h want 0", dut_v);
            end
        end
        reset = 1'b0;
        tick();
        total++;
        if ({grant_valid, grant_idx, grant_onehot} !== {1'b1, 4'd0, 16'h0001}) begin
            bad++;
            $display("FAIL reset_first_grant: got v=%b idx=%0d oh=%h want v=1 idx=0 oh=0001",
                     grant_valid, grant_idx, grant_onehot);
        end
        req = 16'h0000;
        for (int c = 0; c < 3; c++) begin
            tick();
            total++;
            if (dut_v !== exp_v()) begin
                bad++;
                $display("FAIL reset_drain: got %h want %h", dut_v, exp_v());
            end
        end
    endtask

    task automatic test_done_release();
        logic [11:0] pat;
        int run;
        pat = 12'b1110_0111_0011;
        run = 0;
        req = 16'h0020; done = 1'b0;
        for (int c = 0; c < 12; c++) begin
            tick();
            total++;
            if (grant_valid !== pat[11-c] || (grant_valid && grant_idx !== 4'd5) || timeout !== 1'b0) begin
                bad++;
                $display("FAIL done_release c=%0d: got v=%b idx=%0d to=%b want v=%b idx=5 to=0",
                         c, grant_valid, grant_idx, timeout, pat[11-c]);
            end
            total++;
            if (dut_v !== exp_v()) begin
                bad++;
                $display("FAIL done_release_model c=%0d: got %h want %h", c, dut_v, exp_v());
            end
            run  = grant_valid ? run + 1 : 0;
            done = grant_valid && run == 3;
        end
        req = 16'h0000; done = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_wrap();
        int order[5];
        int n;
        bit prev;
        int want[5];
        want = '{0, 1, 15, 0, 1};
        n = 0; prev = 0;
        reset = 1'b1; tick(); reset = 1'b0;
        req = 16'h8003; done = 1'b0;
        for (int c = 0; c < 40 && n < 5; c++) begin
            tick();
            total++;
            if (dut_v !== exp_v()) begin
                bad++;
                $display("FAIL wrap_model c=%0d: got %h want %h", c, dut_v, exp_v());
            end
            done = 1'b0;
            if (grant_valid && !prev) begin
                order[n] = int'(grant_idx);
                n++;
                done = 1'b1;
            end
            prev = grant_valid;
        end
        total++;
        if (n != 5) begin
            bad++;
            $display("FAIL wrap_count: got %0d grants want 5", n);
        end
        for (int i = 0; i < n; i++) begin
            total++;
            if (order[i] != want[i]) begin
                bad++;
                $display("FAIL wrap_order[%0d]: got %0d want %0d", i, order[i], want[i]);
            end
        end
        req = 16'h0000; done = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_timeout(input bit done_at_limit);
        logic [11:0] vpat;
        logic [11:0] tpat;
        int run;
        vpat = 12'b1111_1111_0011;
        tpat = done_at_limit ? 12'b0 : 12'b0000_0000_1000;
        run = 0;
        reset = 1'b1; tick(); reset = 1'b0;
        req = 16'h0100; done = 1'b0;
        for (int c = 0; c < 12; c++) begin
            tick();
            total++;
            if (grant_valid !== vpat[11-c] || timeout !== tpat[11-c] ||
                (grant_valid && grant_idx !== 4'd8)) begin
                bad++;
                $display("FAIL timeout dl=%0d c=%0d: got v=%b idx=%0d to=%b want v=%b idx=8 to=%b",
                         done_at_limit, c, grant_valid, grant_idx, timeout, vpat[11-c], tpat[11-c]);
            end
            total++;
            if (dut_v !== exp_v()) begin
                bad++;
                $display("FAIL timeout_model dl=%0d c=%0d: got %h want %h", done_at_limit, c, dut_v, exp_v());
            end
            run  = grant_valid ? run + 1 : 0;
            done = done_at_limit && grant_valid && run == 8;
        end
        req = 16'h0000; done = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_reset_mid();
        reset = 1'b1; tick(); reset = 1'b0;
        req = 16'h0080; done = 1'b0;
        tick();
        total++;
        if (grant_valid !== 1'b1 || grant_idx !== 4'd7 || grant_onehot !== 16'h0080) begin
            bad++;
            $display("FAIL mid_pre_grant: got v=%b idx=%0d oh=%h want v=1 idx=7 oh=0080",
                     grant_valid, grant_idx, grant_onehot);
        end
        repeat (2) tick();
        reset = 1'b1; req = 16'h0081;
        tick();
        total++;
        if (dut_v !== 22'd0) begin
            bad++;
            $display("FAIL mid_reset_outputs: got %h want 0", dut_v);
        end
        reset = 1'b0;
        tick();
        total++;
        if (grant_valid !== 1'b1 || grant_idx !== 4'd0 || grant_onehot !== 16'h0001) begin
            bad++;
            $display("FAIL mid_post_grant: got v=%b idx=%0d oh=%h want v=1 idx=0 oh=0001",
                     grant_valid, grant_idx, grant_onehot);
        end
        req = 16'h0000;
        repeat (3) tick();
    endtask

    task automatic test_random();
        logic [15:0] mask;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 7) == 0) begin
                mask = 16'($urandom_range(0, 3) == 0 ? 32'hFFFF : (32'h1 << $urandom_range(0, 15)) |
                                                              (32'h1 << $urandom_range(0, 15)));
                req  = 16'($urandom) & mask;
            end
            done  = ($urandom_range(0, 9) == 0);
            reset = ($urandom_range(0, 199) == 0);
            tick();
            total++;
            if (dut_v !== exp_v()) begin
                bad++;
                $display("FAIL random_model c=%0d: got %h want %h", c, dut_v, exp_v());
            end
            total++;
            if (grant_onehot !== (grant_valid ? (16'd1 << grant_idx) : 16'd0) ||
                (timeout && grant_valid)) begin
                bad++;
                $display("FAIL random_invariant c=%0d: got v=%b idx=%0d oh=%h to=%b",
                         c, grant_valid, grant_idx, grant_onehot, timeout);
            end
        end
        reset = 1'b0; done = 1'b0; req = 16'h0000;
    endtask

    initial begin
        total = 0; bad = 0;
        m_owner = -1; m_held = 0; m_gap = 0; m_ptr = 0; m_to = 0;
        reset = 1'b1; req = '0; done = 1'b0;
        test_reset();
        test_done_release();
        test_wrap();
        test_timeout(1'b0);
        test_timeout(1'b1);
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bus_grant_scheduler.md
Name: bus_grant_scheduler

Overview:
- Round-robin scheduler that shares the single system bus among 16 requesters.
- Selects one owner, holds the grant until the owner releases or a hold timeout expires, then inserts a turnaround cycle.
- grant_idx drives the 4-to-16 select decoder that enables the owner's bus drivers.
- grant_onehot is a registered copy of the decoded select, used for local acknowledge.

Parameters:
- NREQ, 16, number of requesters; fixed at 16 to match the 4-bit select decoder.
- IDX_W, 4, width of grant index.
- MAX_HOLD, 8, maximum consecutive cycles one owner may hold the bus; legal range 2..255.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  16  request vector; bit i is high while requester i wants the bus.
- done  input  1  current owner signals end of transfer; ignored unless in GRANT.
- grant_valid  output  1  a grant is active this cycle.
- grant_idx  output  4  index of the current owner; valid only when grant_valid=1.
- grant_onehot  output  16  one-hot owner select; all zeros when grant_valid=0.
- timeout  output  1  one-cycle pulse when a grant is revoked by MAX_HOLD expiry.

Behaviour:
- All outputs are registered.
- Reset, applied at any time including mid-grant, sets the following on the next edge:
  - state = IDLE, grant_valid=0, grant_idx=0, grant_onehot=0, timeout=0
  - priority pointer ptr=0, hold counter=0
- FSM has three states: IDLE, GRANT, TURN.
- IDLE:
  - If req==0, remain in IDLE.
  - Otherwise, at the edge, choose the winner w = first set bit of req searching from ptr upward, modulo 16 (wraps 15->0).
  - Go to GRANT with grant_idx=w, grant_onehot=1<<w, grant_valid=1, counter=0.
  - Latency is one cycle from req sampled to grant_valid high.
- GRANT: the counter increments each cycle. Release conditions, evaluated each edge:
  - (a) done=1
  - (b) req[grant_idx]=0 (owner withdrew)
  - (c) counter==MAX_HOLD-1 (timeout)
- On any release condition:
  - Go to TURN and set ptr = grant_idx+1 mod 16.
  - grant_valid, grant_idx and grant_onehot clear on that edge.
  - timeout=1 for exactly the TURN cycle, and only if (c) held and neither (a) nor (b) held. Done or withdrawal has priority over timeout.
- TURN:
  - Lasts exactly one cycle with grant_valid=0.
  - Always goes to IDLE; no arbitration happens in TURN.
- Back-to-back ownership: the last GRANT cycle is followed by TURN, then IDLE, then a new GRANT. This gives exactly 2 cycles with grant_valid=0 between owners.
- The owner therefore holds the bus for at most MAX_HOLD cycles.
- A requester that was just served has lowest priority in the next arbitration.
- A sole requester is re-granted after the 2-cycle gap.
- req changes from non-owners during GRANT have no effect.
- done asserted outside GRANT is ignored.
- Invariants:
  - grant_onehot == (grant_valid ? 1<<grant_idx : 0) in every cycle.
  - grant_onehot is never multi-hot.
  - timeout never coincides with grant_valid=1.

Test Plan:
- Reset held 2 cycles with req=16'hFFFF -> all outputs 0; after release, first grant is idx 0 one cycle later, grant_onehot=16'h0001.
- req=16'h0020 held, done pulsed on 3rd GRANT cycle -> grant_valid high 3 cycles, idx=5, then 2 low cycles, then re-grant idx 5; timeout stays 0.
- req=16'h8003 constant, done pulsed on each grant's first cycle -> grant order 0,1,15,0,1 (wrap 15->0 verified).
- req=16'h0100, never done, MAX_HOLD=8 -> grant idx 8 for exactly 8 cycles; timeout=1 for one cycle coincident with grant_valid=0.
- done=1 on exactly the 8th GRANT cycle -> release happens; timeout stays 0 (done priority).
- Reset asserted mid-grant (idx 7) -> next cycle all outputs 0, ptr=0; with req=16'h0081, next grant is idx 0.
